// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling constants and the receiver state
// encoding. The receiver uses this package, and the baud generator and the
// future transmitter are meant to share it as well.
package uart_pkg;

  localparam int OS_RATE  = 16;  // oversample ticks per bit
  localparam int MID_TICK = 7;   // tick index closest to the middle of a bit

  // Fixed encodings so existing logic analyser setups keep decoding the bus.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports: clk, reset (async, active-high), d (async in), q (synchronized out).
// RST_VAL is the value both flops take in reset.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampling UART receiver with optional parity and a one-entry
// output register with valid/ready handshake.
// Ports:
//   clk, reset      - clock, async active-high reset
//   tick            - 16x baud enable pulse
//   rx              - async serial input (idle high)
//   parity_en/odd   - parity configuration, captured at the start of a frame
//   dout/dout_valid/dout_ready - received frame handshake
//   frame_err/parity_err       - error flags belonging to the held frame
//   overrun         - 1-clk pulse when a finished frame is dropped
//   busy            - receiver FSM not idle
module uart_rx_os #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       rx,
  input  logic       parity_en,
  input  logic       parity_odd,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);

  import uart_pkg::*;

  localparam logic [3:0] MID_T     = 4'(MID_TICK);
  localparam logic [3:0] LAST_T    = 4'(OS_RATE - 1);
  localparam logic [2:0] N_LAST    = 3'(DBIT - 1);
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);

  logic       rx_s;
  rx_state_t  state;
  logic [3:0] s;
  logic       s_hi;      // fifth tick-count bit, only used for 2 stop bits
  logic [2:0] n;
  logic [7:0] b;
  logic       par_en_q;
  logic       par_odd_q;
  logic       par_err_q;
  logic [7:0] data_c;
  logic       done;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // Bits enter at the MSB, so after DBIT shifts the frame sits in the top
  // DBIT bits; move it down to LSB alignment with zeroed upper bits.
  assign data_c = b >> (8 - DBIT);

  assign done = (state == STOP) && tick && ({s_hi, s} == STOP_LAST);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      s         <= '0;
      s_hi      <= 1'b0;
      n         <= '0;
      b         <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s     <= '0;
            s_hi  <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            if (s == MID_T) begin
              if (!rx_s) begin
                state     <= DATA;
                s         <= '0;
                n         <= '0;
                b         <= '0;
                par_en_q  <= parity_en;
                par_odd_q <= parity_odd;
                par_err_q <= 1'b0;
              end else begin
                state <= IDLE;  // start bit too short: treat as a glitch
              end
            end else begin
              s <= s + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s == LAST_T) begin
              s <= '0;
              b <= {rx_s, b[7:1]};
              if (n == N_LAST) state <= par_en_q ? PARITY : STOP;
              else             n     <= n + 3'd1;
            end else begin
              s <= s + 4'd1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            if (s == LAST_T) begin
              s         <= '0;
              // Expected bit is XOR(data)^odd; any difference is an error.
              par_err_q <= rx_s ^ (^data_c) ^ par_odd_q;
              state     <= STOP;
            end else begin
              s <= s + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if ({s_hi, s} == STOP_LAST) begin
              state <= IDLE;
              s     <= '0;
              s_hi  <= 1'b0;
            end else begin
              {s_hi, s} <= {s_hi, s} + 5'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output register: a finished frame loads if the slot is free or is being
  // drained this cycle; otherwise the old frame wins and the new one is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!dout_valid || dout_ready) begin
          dout       <= data_c;
          frame_err  <= ~rx_s;
          parity_err <= par_en_q & par_err_q;
          dout_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 SHALL have parameter DBIT, default 8, data bits per frame (5..8).
REQ-002 SHALL have parameter SB_TICK, default 16, oversample ticks for the stop bit (16 = 1 stop bit, 32 = 2 stop bits).
REQ-003 SHALL have port clk, input, 1, system clock; rising-edge active.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port tick, input, 1, one-clk pulse at 16x the baud rate, from the baud generator.
REQ-006 SHALL have port rx, input, 1, asynchronous serial line; idles high.
REQ-007 SHALL have port parity_en, input, 1, parity bit expected after the data bits when 1.
REQ-008 SHALL have port parity_odd, input, 1, odd parity when 1, even parity when 0.
REQ-009 SHALL have port dout, output, 8, received data, LSB-aligned, unused MSBs 0.
REQ-010 SHALL have port dout_valid, output, 1, dout and error flags hold a frame.
REQ-011 SHALL have port dout_ready, input, 1, consumer accepts the frame when asserted with dout_valid.
REQ-012 SHALL have port frame_err, output, 1, stop bit sampled low for the held frame.
REQ-013 SHALL have port parity_err, output, 1, parity mismatch for the held frame.
REQ-014 SHALL have port overrun, output, 1, one-clk pulse when a completed frame is dropped.
REQ-015 SHALL have port busy, output, 1, 1 whenever the FSM is not in IDLE.

Function
REQ-016 SHALL pass rx through a 2-flop synchronizer; all FSM decisions use the synchronized value rx_s.
REQ-017 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, using a 4-bit tick counter s and a 3-bit bit counter n.
REQ-018 IDLE: when rx_s==0, SHALL go to START with s=0, independent of tick.
REQ-019 START: on each tick, s increments; at s==7, rx_s==0 SHALL go to DATA (s=0, n=0) and rx_s==1 SHALL return to IDLE (glitch reject, no output).
REQ-020 DATA: on the tick where s==15, SHALL shift rx_s in LSB first and clear s; when n==DBIT-1, SHALL go to PARITY if parity_en else STOP, otherwise increment n.
REQ-021 PARITY: on the tick where s==15, SHALL sample rx_s, compute the parity error against XOR(data)^parity_odd, clear s, and go to STOP.
REQ-022 STOP: on the tick where s==SB_TICK-1 (5-bit compare when SB_TICK=32), SHALL sample rx_s, set the frame error if it is 0, raise the completion strobe, and go to IDLE.
REQ-023 Ticks SHALL be counted only in START, DATA, PARITY and STOP; between ticks, state and counters SHALL hold.
REQ-024 parity_en and parity_odd SHALL be sampled at the START->DATA transition and held for the rest of the frame.
REQ-025 On completion with the output register empty, or being consumed in the same cycle, SHALL load dout/frame_err/parity_err and assert dout_valid on the next clk.
REQ-026 On completion with dout_valid=1 and dout_ready=0, SHALL keep the old frame, drop the new one, and pulse overrun for 1 clk.
REQ-027 dout_valid SHALL clear the clk after dout_valid&&dout_ready unless a new frame loads in that same cycle.
REQ-028 A frame with frame_err SHALL still be delivered, with its data.
REQ-029 Frame latency SHALL be 2 clk synchronizer + frame ticks + 1 clk register.

Reset
REQ-030 Reset SHALL put the FSM in IDLE and clear s, n and the shift register.
REQ-031 Reset SHALL set dout=0, dout_valid=0, frame_err=0, parity_err=0, overrun=0 and busy=0; both synchronizer flops SHALL reset to 1.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no output; after release, the block SHALL wait for a new falling edge.

Structure
REQ-033 Package uart_pkg SHALL hold the rx_state_t enum, OS_RATE=16 and MID_TICK=7; baud_gen and the future uart_tx SHALL share it.
REQ-034 Sub-module uart_sync2 SHALL be the 2-flop synchronizer (reset value parameter, default 1); all other logic SHALL be inline.

Verification
REQ-035 tick every clk, 8N1, send 0xA5 with dout_ready=1 -> one dout_valid pulse, dout=0xA5, both error flags 0.
REQ-036 parity_en=1, parity_odd=0, send 0x03 with parity bit 1 -> dout=0x03, parity_err=1; with parity bit 0 -> parity_err=0.
REQ-037 rx low for 4 ticks only -> FSM returns to IDLE, no dout_valid, busy drops.
REQ-038 dout_ready=0, send 0x11 then 0x22 -> dout stays 0x11, 1-clk overrun at the second completion; ready then -> dout_valid drops.
REQ-039 stop bit driven 0 on 0x7E -> dout=0x7E, frame_err=1; reset at the 3rd data bit -> all outputs 0, next frame 0x5A received correctly.
